// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, next-PC selection and the imem read port.
// Optional stall counter output enabled by defining IF_STALL_CNT_EN.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NO_OP    = 16'hF000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_hazard,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        call,
    input  logic [11:0] call_target,
    input  logic        ret_control,
    input  logic        ret_PC,
    input  logic [15:0] ret_addr,
    input  logic        halt,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic        imem_rd_en,
    output logic [15:0] instruction_out,
    output logic [15:0] PC_out,
    output logic        PC_hazard,
    output logic        halted
`ifdef IF_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALTED   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_pc_inc;
    logic        w_redirect;

    assign w_pc_inc = r_pc + 16'd1;

    // Stage boundary: PC and state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_redirect  = 1'b0;
        case (r_state)
            S_RUN: begin
                if (halt) begin
                    w_state_nxt = S_HALTED;
                end else if (ret_PC) begin
                    w_pc_nxt   = ret_addr;
                    w_redirect = 1'b1;
                end else if (branch_taken) begin
                    // A taken branch flushes the stalled slot, so it beats data_hazard.
                    w_pc_nxt   = branch_target;
                    w_redirect = 1'b1;
                end else if (call) begin
                    w_pc_nxt   = {w_pc_inc[15:12], call_target};
                    w_redirect = 1'b1;
                end else if (ret_control) begin
                    w_state_nxt = S_RET_WAIT;
                end else if (!data_hazard) begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            S_RET_WAIT: begin
                if (halt) begin
                    w_state_nxt = S_HALTED;
                end else if (ret_PC) begin
                    w_pc_nxt    = ret_addr;
                    w_redirect  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign imem_addr       = r_pc;
    assign PC_out          = w_pc_inc;
    assign imem_rd_en      = (r_state == S_RUN);
    assign instruction_out = (r_state == S_RUN) ? imem_data : NO_OP;
    assign PC_hazard       = w_redirect && !rst;
    assign halted          = (r_state == S_HALTED);

`ifdef IF_STALL_CNT_EN
    logic [15:0] r_stall_count;
    logic        w_stall;

    assign w_stall = ((r_state == S_RUN) && data_hazard && !w_redirect) ||
                     (r_state == S_RET_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan scenarios plus randomized
// stimulus compared every cycle against a behavioural fetch model.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        data_hazard;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        call;
    logic [11:0] call_target;
    logic        ret_control;
    logic        ret_PC;
    logic [15:0] ret_addr;
    logic        halt;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] instruction_out;
    logic [15:0] PC_out;
    logic        PC_hazard;
    logic        halted;
`ifdef IF_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    int checks;
    int errors;

    // Model state: mode 0 = fetching, 1 = waiting for return address, 2 = halted
    logic [15:0] m_pc;
    int          m_mode;
    int          m_stall;

    if_stage #(.RESET_PC(16'h0000), .NO_OP(16'hF000)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_hazard    (data_hazard),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .call           (call),
        .call_target    (call_target),
        .ret_control    (ret_control),
        .ret_PC         (ret_PC),
        .ret_addr       (ret_addr),
        .halt           (halt),
        .imem_data      (imem_data),
        .imem_addr      (imem_addr),
        .imem_rd_en     (imem_rd_en),
        .instruction_out(instruction_out),
        .PC_out         (PC_out),
        .PC_hazard      (PC_hazard),
        .halted         (halted)
`ifdef IF_STALL_CNT_EN
        ,
        .stall_count    (stall_count)
`endif
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction

    assign imem_data = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        data_hazard   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        call          = 1'b0;
        call_target   = 12'h000;
        ret_control   = 1'b0;
        ret_PC        = 1'b0;
        ret_addr      = 16'h0000;
        halt          = 1'b0;
    endtask

    // Redirect target chosen this cycle by the model, or -1 when there is none.
    function automatic int model_redirect();
        logic [15:0] seq;
        seq = m_pc + 16'd1;
        if (rst || halt) return -1;
        if (m_mode == 0) begin
            if (ret_PC)       return int'(ret_addr);
            if (branch_taken) return int'(branch_target);
            if (call)         return int'({seq[15:12], call_target});
            return -1;
        end
        if (m_mode == 1 && ret_PC) return int'(ret_addr);
        return -1;
    endfunction

    task automatic compare_model();
        logic [15:0] seq;
        seq = m_pc + 16'd1;
        chk("imem_addr", {16'h0, imem_addr}, {16'h0, m_pc});
        chk("PC_out", {16'h0, PC_out}, {16'h0, seq});
        chk("imem_rd_en", {31'h0, imem_rd_en}, (m_mode == 0) ? 32'd1 : 32'd0);
        chk("instruction_out", {16'h0, instruction_out},
            {16'h0, (m_mode == 0) ? mem_word(m_pc) : 16'hF000});
        chk("PC_hazard", {31'h0, PC_hazard}, (model_redirect() >= 0) ? 32'd1 : 32'd0);
        chk("halted", {31'h0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
`ifdef IF_STALL_CNT_EN
        chk("stall_count", {16'h0, stall_count}, m_stall);
`endif
    endtask

    task automatic model_advance();
        int tgt;
        tgt = model_redirect();
        if ((m_mode == 0 && data_hazard && tgt < 0) || m_mode == 1)
            if (m_stall < 16'hFFFF) m_stall++;
        if (m_mode == 2) begin
        end else if (halt) begin
            m_mode = 2;
        end else if (tgt >= 0) begin
            m_pc   = tgt[15:0];
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (ret_control)       m_mode = 1;
            else if (!data_hazard) m_pc = m_pc + 16'd1;
        end
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic cycle();
        #1;
        compare_model();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_pc    = 16'h0000;
        m_mode  = 0;
        m_stall = 0;
        chk("async_reset_addr", {16'h0, imem_addr}, 32'h0000);
        compare_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic jump_to(input logic [15:0] a);
        clear_inputs();
        branch_taken  = 1'b1;
        branch_target = a;
        cycle();
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        do_reset();
        chk("reset_halted", {31'h0, halted}, 32'd0);
        chk("reset_instr", {16'h0, instruction_out}, {16'h0, mem_word(16'h0000)});

        // Sequential fetch after reset
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            #1;
            chk("seq_addr", {16'h0, imem_addr}, i);
            chk("seq_pcout", {16'h0, PC_out}, i + 1);
            cycle();
        end

        // Branch
        jump_to(16'h0010);
        branch_taken = 1'b1; branch_target = 16'h0040;
        #1;
        chk("br_hazard", {31'h0, PC_hazard}, 32'd1);
        cycle();
        clear_inputs(); #1;
        chk("br_addr", {16'h0, imem_addr}, 32'h0040);

        // Call keeps the upper nibble of PC+1
        jump_to(16'h3005);
        call = 1'b1; call_target = 12'hABC;
        #1;
        chk("call_hazard", {31'h0, PC_hazard}, 32'd1);
        cycle();
        clear_inputs(); #1;
        chk("call_addr", {16'h0, imem_addr}, 32'h3ABC);

        // Data hazard hold
        jump_to(16'h0020);
        for (int i = 0; i < 3; i++) begin
            data_hazard = 1'b1; #1;
            chk("dh_addr", {16'h0, imem_addr}, 32'h0020);
            chk("dh_hazard", {31'h0, PC_hazard}, 32'd0);
            cycle();
        end
        clear_inputs(); #1;
        chk("dh_release", {16'h0, imem_addr}, 32'h0020);
        cycle();
        #1;
        chk("dh_next", {16'h0, imem_addr}, 32'h0021);

        // Return parking
        jump_to(16'h0050);
        ret_control = 1'b1;
        cycle();
        clear_inputs(); branch_taken = 1'b1; branch_target = 16'h0999; #1;
        chk("rw_instr", {16'h0, instruction_out}, 32'hF000);
        chk("rw_rd_en", {31'h0, imem_rd_en}, 32'd0);
        chk("rw_addr", {16'h0, imem_addr}, 32'h0050);
        cycle();
        clear_inputs(); ret_PC = 1'b1; ret_addr = 16'h0123; #1;
        chk("rw_hazard", {31'h0, PC_hazard}, 32'd1);
        cycle();
        clear_inputs(); #1;
        chk("ret_addr", {16'h0, imem_addr}, 32'h0123);
        chk("ret_rd_en", {31'h0, imem_rd_en}, 32'd1);

        // Halt is absorbing
        jump_to(16'h0077);
        halt = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            branch_taken = 1'b1; branch_target = 16'h1111; ret_PC = 1'b1; #1;
            chk("h_halted", {31'h0, halted}, 32'd1);
            chk("h_addr", {16'h0, imem_addr}, 32'h0077);
            chk("h_rd_en", {31'h0, imem_rd_en}, 32'd0);
            cycle();
        end
        clear_inputs();
        do_reset();
        #1;
        chk("h_reset_addr", {16'h0, imem_addr}, 32'h0000);
        chk("h_reset_halted", {31'h0, halted}, 32'd0);

        // PC wraps
        jump_to(16'hFFFF);
        #1;
        chk("wrap_pcout", {16'h0, PC_out}, 32'h0000);
        cycle();
        #1;
        chk("wrap_addr", {16'h0, imem_addr}, 32'h0000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0 || (m_mode == 2 && $urandom_range(7) == 0)) begin
                clear_inputs();
                if ($urandom_range(1) == 1) begin
                    data_hazard = 1'b1; branch_taken = 1'b1; ret_PC = 1'b1;
                end
                do_reset();
            end else begin
                data_hazard   = ($urandom_range(3) == 0);
                branch_taken  = ($urandom_range(7) == 0);
                branch_target = 16'($urandom);
                call          = ($urandom_range(7) == 0);
                call_target   = 12'($urandom);
                ret_control   = ($urandom_range(7) == 0);
                ret_PC        = ($urandom_range(9) == 0);
                ret_addr      = 16'($urandom);
                halt          = ($urandom_range(149) == 0);
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
